// File: rtl/matrix_dma_loader.sv
// matrix_dma_loader
//   Bus-master engine for the memory-mapped matrix accelerator at ACCEL_BASE.
//   On a start pulse it unpacks 8-bit A and B matrices from system memory into
//   the accelerator's one-element-per-word window. It then resets and starts
//   the accelerator and polls STATUS until the done bit is set. Finally it
//   copies the 32-bit C matrix back to system memory.
//
//   Optional build macro: MATRIX_DMA_TIMEOUT_EN
//     When defined, polling gives up after POLL_TIMEOUT status reads. err is
//     then set and the C copy is skipped.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cfg_start            single-cycle start request (honoured only when idle)
//   cfg_src_a/src_b      byte addresses of packed A / B (4 elements per word)
//   cfg_dst_c            byte address for C (one word per element)
//   busy, done, err      status: busy while running, done pulse, sticky error
//   m_valid/m_ready      master request / slave completion handshake
//   m_addr/m_wdata       transaction address / write data
//   m_wstrb              byte strobes, 0 means read
//   m_rdata              read data, captured on the completing edge
module matrix_dma_loader #(
    parameter int unsigned M            = 4,
    parameter int unsigned N            = 4,
    parameter int unsigned P            = 4,
    parameter logic [31:0] ACCEL_BASE   = 32'h1000_0000,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [31:0] cfg_src_a,
    input  logic [31:0] cfg_src_b,
    input  logic [31:0] cfg_dst_c,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata
);
    localparam int unsigned NA    = M * N;
    localparam int unsigned NB    = N * P;
    localparam int unsigned NC    = M * P;
    localparam int unsigned MAXAB = (NA > NB) ? NA : NB;
    localparam int unsigned MAXE  = (MAXAB > NC) ? MAXAB : NC;
    localparam int unsigned CW    = $clog2(MAXE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_CTRL, S_POLL, S_STORE_C, S_FIN
    } state_t;

    state_t        r_state;
    logic          r_rd_phase;  // next transaction of an element loop is its read
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_src_a, r_src_b, r_dst_c, r_word;
    logic          r_busy, r_done, r_err, r_m_valid;
    logic [31:0]   r_m_addr, r_m_wdata;
    logic [3:0]    r_m_wstrb;
`ifdef MATRIX_DMA_TIMEOUT_EN
    localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
    logic [PW-1:0] r_poll;
`endif

    logic [31:0] w_k, w_k_next, w_k4, w_last, w_addr, w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic        w_misaligned, w_loop_end, w_word_end;

    always_comb begin
        w_k          = 32'(r_cnt);
        w_k_next     = w_k + 32'd1;
        w_k4         = w_k << 2;
        w_byte       = r_word[{w_k[1:0], 3'b000} +: 8];
        w_misaligned = |{cfg_src_a[1:0], cfg_src_b[1:0], cfg_dst_c[1:0]};
        w_last       = '0;
        w_addr       = '0;
        w_wdata      = '0;
        w_wstrb      = '0;
        case (r_state)
            // In the read phase k is a multiple of 4, so src + k is src + 4w.
            S_LOAD_A: begin
                w_last = 32'(NA);
                if (r_rd_phase) begin
                    w_addr = r_src_a + w_k;
                end else begin
                    w_addr  = ACCEL_BASE + w_k4;
                    w_wdata = {24'h0, w_byte};
                    w_wstrb = 4'b0001;
                end
            end
            S_LOAD_B: begin
                w_last = 32'(NB);
                if (r_rd_phase) begin
                    w_addr = r_src_b + w_k;
                end else begin
                    w_addr  = ACCEL_BASE + 32'h40 + w_k4;
                    w_wdata = {24'h0, w_byte};
                    w_wstrb = 4'b0001;
                end
            end
            S_CTRL: begin
                w_addr  = ACCEL_BASE + 32'h100;
                w_wstrb = 4'hF;
                case (w_k[1:0])
                    2'd0:    w_wdata = 32'h2;
                    2'd1:    w_wdata = 32'h0;
                    default: w_wdata = 32'h1;
                endcase
            end
            S_POLL: w_addr = ACCEL_BASE + 32'h104;
            S_STORE_C: begin
                w_last = 32'(NC);
                if (r_rd_phase) begin
                    w_addr = ACCEL_BASE + 32'h80 + w_k4;
                end else begin
                    w_addr  = r_dst_c + w_k4;
                    w_wdata = r_word;
                    w_wstrb = 4'hF;
                end
            end
            default: ;
        endcase
        w_loop_end = (w_k_next == w_last);
        w_word_end = (w_k_next[1:0] == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd_phase <= 1'b1;
            r_cnt      <= '0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_dst_c    <= '0;
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_wstrb  <= '0;
`ifdef MATRIX_DMA_TIMEOUT_EN
            r_poll     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_src_a    <= cfg_src_a;
                        r_src_b    <= cfg_src_b;
                        r_dst_c    <= cfg_dst_c;
                        r_err      <= w_misaligned;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_rd_phase <= 1'b1;
                        r_state    <= w_misaligned ? S_FIN : S_LOAD_A;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    // Issue only from an idle bus cycle: this enforces the
                    // single low cycle of m_valid between transactions.
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_addr  <= w_addr;
                        r_m_wdata <= w_wdata;
                        r_m_wstrb <= w_wstrb;
                    end else if (m_ready) begin
                        r_m_valid <= 1'b0;
                        case (r_state)
                            S_LOAD_A, S_LOAD_B, S_STORE_C: begin
                                if (r_rd_phase) begin
                                    r_word     <= m_rdata;
                                    r_rd_phase <= 1'b0;
                                end else if (w_loop_end) begin
                                    r_cnt      <= '0;
                                    r_rd_phase <= 1'b1;
                                    case (r_state)
                                        S_LOAD_A: r_state <= S_LOAD_B;
                                        S_LOAD_B: r_state <= S_CTRL;
                                        default:  r_state <= S_FIN;
                                    endcase
                                end else begin
                                    r_cnt <= r_cnt + CW'(1);
                                    // STORE_C reads every element; loads read per word.
                                    r_rd_phase <= (r_state == S_STORE_C) ? 1'b1 : w_word_end;
                                end
                            end
                            S_CTRL: begin
                                if (w_k == 32'd2) begin
                                    r_cnt   <= '0;
                                    r_state <= S_POLL;
`ifdef MATRIX_DMA_TIMEOUT_EN
                                    r_poll  <= '0;
`endif
                                end else begin
                                    r_cnt <= r_cnt + CW'(1);
                                end
                            end
                            S_POLL: begin
                                if (m_rdata[1]) begin
                                    r_cnt      <= '0;
                                    r_rd_phase <= 1'b1;
                                    r_state    <= S_STORE_C;
                                end
`ifdef MATRIX_DMA_TIMEOUT_EN
                                else if (32'(r_poll) == POLL_TIMEOUT - 1) begin
                                    r_err   <= 1'b1;
                                    r_state <= S_FIN;
                                end else begin
                                    r_poll <= r_poll + PW'(1);
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;

endmodule

// File: tb/tb_matrix_dma_loader.sv
// tb_matrix_dma_loader
//   Scoreboard bench for matrix_dma_loader. Every expected bus transaction is
//   queued when a run is launched, and then popped and compared as the slave
//   completes each transaction. The slave models system memory and the
//   accelerator window, with a configurable number of wait states.
module tb_matrix_dma_loader;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n, cfg_start;
    logic [31:0] cfg_src_a, cfg_src_b, cfg_dst_c;
    logic        busy, done, err, m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic [3:0]  m_wstrb;

    matrix_dma_loader #(
        .M(4), .N(4), .P(4), .ACCEL_BASE(BASE), .POLL_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .cfg_dst_c(cfg_dst_c),
        .busy(busy), .done(done), .err(err),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    txn_t        sb_q[$];
    int          checks = 0, failures = 0;
    logic [31:0] sysmem [0:255];
    logic [31:0] acc_a [0:15];
    logic [31:0] acc_b [0:15];
    logic [31:0] acc_c [0:15];
    logic [31:0] c_exp [0:15];
    logic        acc_run = 1'b0;
    int          acc_polls = 0, polls_needed = 5, wait_cycles = 0;
    int          n_txn = 0, n_status = 0, n_sys_writes = 0, n_done = 0, n_valid = 0;
    bit          seen_b_write = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.addr = a; t.data = d; t.strb = s;
        sb_q.push_back(t);
    endtask

    task automatic acc_compute();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] s;
                s = 32'h0;
                for (int k = 0; k < 4; k++)
                    s += 32'(acc_a[i*4+k][7:0]) * 32'(acc_b[k*4+j][7:0]);
                acc_c[i*4+j] = s;
            end
    endtask

    // Slave response for the transaction completing at the next rising edge.
    task automatic serve();
        txn_t e;
        n_txn++;
        check("sb_avail", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("txn_addr", m_addr, e.addr);
            check("txn_strb", 32'(m_wstrb), 32'(e.strb));
            if (e.strb != 4'h0) check("txn_wdata", m_wdata, e.data);
        end
        m_rdata = 32'hDEAD_BEEF;
        if (m_addr < 32'h400) begin
            if (m_wstrb == 4'h0) m_rdata = sysmem[m_addr[9:2]];
            else begin
                sysmem[m_addr[9:2]] = m_wdata;
                n_sys_writes++;
            end
        end else if (m_addr >= BASE && m_addr < BASE + 32'h40) begin
            if (m_wstrb != 4'h0) acc_a[m_addr[5:2]] = m_wdata;
        end else if (m_addr >= BASE + 32'h40 && m_addr < BASE + 32'h80) begin
            if (m_wstrb != 4'h0) begin
                acc_b[m_addr[5:2]] = m_wdata;
                seen_b_write = 1'b1;
            end
        end else if (m_addr >= BASE + 32'h80 && m_addr < BASE + 32'hC0) begin
            if (m_wstrb == 4'h0) m_rdata = acc_c[m_addr[5:2]];
        end else if (m_addr == BASE + 32'h100 && m_wstrb != 4'h0) begin
            if (m_wdata == 32'h2) begin
                acc_run = 1'b0; acc_polls = 0;
            end else if (m_wdata == 32'h1) begin
                acc_compute(); acc_run = 1'b1; acc_polls = 0;
            end
        end else if (m_addr == BASE + 32'h104 && m_wstrb == 4'h0) begin
            n_status++;
            acc_polls++;
            m_rdata = (acc_run && acc_polls >= polls_needed) ? 32'h2 : 32'h0;
        end
    endtask

    logic        hold = 1'b0, comp1 = 1'b0, comp2 = 1'b0;
    int          wcnt = 0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b0; hold = 1'b0; wcnt = 0; comp1 = 1'b0; comp2 = 1'b0;
        end else begin
            comp2 = comp1;
            comp1 = m_ready;  // ready was only raised with valid high: completed
            if (comp1) check("gap_low", 32'(m_valid), 32'd0);
            else if (comp2 && sb_q.size() != 0) check("gap_one", 32'(m_valid), 32'd1);
            m_ready = 1'b0;
            if (m_valid) begin
                n_valid++;
                if (!hold) begin
                    hold = 1'b1; wcnt = 0;
                    h_addr = m_addr; h_data = m_wdata; h_strb = m_wstrb;
                end else begin
                    check("stable_addr", m_addr, h_addr);
                    check("stable_wdata", m_wdata, h_data);
                    check("stable_wstrb", 32'(m_wstrb), 32'(h_strb));
                end
                if (wcnt >= wait_cycles) begin
                    m_ready = 1'b1;
                    hold = 1'b0;
                    serve();
                end else wcnt++;
            end
        end
    end

    always @(negedge clk) if (rst_n && done) n_done++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load_mats(input logic [31:0] sa, input logic [31:0] sb, input bit rnd);
        logic [31:0] wa, wb, ad;
        for (int wi = 0; wi < 4; wi++) begin
            for (int b = 0; b < 4; b++) begin
                int k;
                k = 4*wi + b;
                wa[8*b +: 8] = rnd ? 8'($urandom_range(0, 255)) : 8'(k + 1);
                wb[8*b +: 8] = rnd ? 8'($urandom_range(0, 255)) : ((k/4 == k%4) ? 8'd1 : 8'd0);
            end
            ad = sa + 32'(4*wi); sysmem[ad[9:2]] = wa;
            ad = sb + 32'(4*wi); sysmem[ad[9:2]] = wb;
        end
    endtask

    task automatic fill_dst(input logic [31:0] dc);
        logic [31:0] ad;
        for (int j = 0; j < 16; j++) begin
            ad = dc + 32'(4*j);
            sysmem[ad[9:2]] = 32'hA5A5_0000 | 32'(j);
        end
    endtask

    task automatic build_expected(input logic [31:0] sa, input logic [31:0] sb,
                                  input logic [31:0] dc, input int npolls, input bit with_c);
        logic [7:0]  ea [0:15];
        logic [7:0]  eb [0:15];
        logic [31:0] w, ad;
        for (int k = 0; k < 16; k++) begin
            ad = sa + 32'(4*(k/4)); w = sysmem[ad[9:2]]; ea[k] = w[8*(k%4) +: 8];
            ad = sb + 32'(4*(k/4)); w = sysmem[ad[9:2]]; eb[k] = w[8*(k%4) +: 8];
        end
        for (int wi = 0; wi < 4; wi++) begin
            push(sa + 32'(4*wi), 32'h0, 4'h0);
            for (int b = 0; b < 4; b++)
                push(BASE + 32'(4*(4*wi+b)), {24'h0, ea[4*wi+b]}, 4'b0001);
        end
        for (int wi = 0; wi < 4; wi++) begin
            push(sb + 32'(4*wi), 32'h0, 4'h0);
            for (int b = 0; b < 4; b++)
                push(BASE + 32'h40 + 32'(4*(4*wi+b)), {24'h0, eb[4*wi+b]}, 4'b0001);
        end
        push(BASE + 32'h100, 32'h2, 4'hF);
        push(BASE + 32'h100, 32'h0, 4'hF);
        push(BASE + 32'h100, 32'h1, 4'hF);
        repeat (npolls) push(BASE + 32'h104, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c_exp[i*4+j] = 32'h0;
                for (int k = 0; k < 4; k++)
                    c_exp[i*4+j] += 32'(ea[i*4+k]) * 32'(eb[k*4+j]);
            end
        if (with_c)
            for (int j = 0; j < 16; j++) begin
                push(BASE + 32'h80 + 32'(4*j), 32'h0, 4'h0);
                push(dc + 32'(4*j), c_exp[j], 4'hF);
            end
    endtask

    task automatic start_run(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] dc);
        cfg_src_a = sa; cfg_src_b = sb; cfg_dst_c = dc; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick(); n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    // Full run with result checks; npolls is what the accelerator model needs.
    task automatic full_run(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] dc,
                            input bit identity_check);
        int t0, d0, s0;
        logic [31:0] ad;
        fill_dst(dc);
        build_expected(sa, sb, dc, 5, 1'b1);
        t0 = n_txn; d0 = n_done; s0 = n_status;
        start_run(sa, sb, dc);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(3000);
        tick(); tick();
        check("done_once", 32'(n_done - d0), 32'd1);
        check("err_clear", 32'(err), 32'd0);
        check("txn_count", 32'(n_txn - t0), 32'd80);
        check("status_reads", 32'(n_status - s0), 32'd5);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        for (int j = 0; j < 16; j++) begin
            ad = dc + 32'(4*j);
            check("c_mem", sysmem[ad[9:2]], identity_check ? 32'(j + 1) : c_exp[j]);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int v0, t0, d0, s0, w0, n;
        rst_n = 1'b0; cfg_start = 1'b0;
        cfg_src_a = '0; cfg_src_b = '0; cfg_dst_c = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_addr", m_addr, 32'd0);
        check("rst_wdata", m_wdata, 32'd0);
        check("rst_wstrb", 32'(m_wstrb), 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero-wait slave, A = 1..16, B = identity.
        polls_needed = 5; wait_cycles = 0;
        load_mats(32'h100, 32'h200, 1'b0);
        full_run(32'h100, 32'h200, 32'h300, 1'b1);

        // Three wait states on every transaction.
        wait_cycles = 3;
        full_run(32'h100, 32'h200, 32'h300, 1'b1);
        wait_cycles = 0;

        // Misaligned source B: error, no bus traffic.
        v0 = n_valid; d0 = n_done;
        start_run(32'h100, 32'h202, 32'h300);
        check("mis_err", 32'(err), 32'd1);
        check("mis_busy", 32'(busy), 32'd1);
        check("mis_done_early", 32'(done), 32'd0);
        tick();
        check("mis_done", 32'(done), 32'd1);
        check("mis_busy_end", 32'(busy), 32'd0);
        tick();
        check("mis_done_pulse", 32'(done), 32'd0);
        check("mis_err_sticky", 32'(err), 32'd1);
        repeat (5) tick();
        check("mis_no_valid", 32'(n_valid - v0), 32'd0);
        check("mis_done_once", 32'(n_done - d0), 32'd1);

        // Second start while busy is ignored; random matrices.
        load_mats(32'h000, 32'h080, 1'b1);
        fill_dst(32'h380);
        build_expected(32'h000, 32'h080, 32'h380, 5, 1'b1);
        d0 = n_done; t0 = n_txn;
        start_run(32'h000, 32'h080, 32'h380);
        repeat (10) tick();
        start_run(32'h100, 32'h200, 32'h300);
        wait_done(3000);
        tick(); tick();
        check("dbl_done_once", 32'(n_done - d0), 32'd1);
        check("dbl_err", 32'(err), 32'd0);
        check("dbl_txn_count", 32'(n_txn - t0), 32'd80);
        check("dbl_sb_drained", 32'(sb_q.size()), 32'd0);
        for (int j = 0; j < 16; j++)
            check("dbl_c_mem", sysmem[(32'h380 >> 2) + j], c_exp[j]);

        // Reset pulse during LOAD_B, then a clean rerun.
        load_mats(32'h100, 32'h200, 1'b0);
        build_expected(32'h100, 32'h200, 32'h300, 5, 1'b1);
        seen_b_write = 1'b0;
        start_run(32'h100, 32'h200, 32'h300);
        n = 0;
        while (!seen_b_write && n < 500) begin
            tick(); n++;
        end
        check("reach_load_b", 32'(seen_b_write), 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        tick();
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        t0 = n_txn;
        repeat (5) tick();
        check("abort_no_txn", 32'(n_txn - t0), 32'd0);
        full_run(32'h100, 32'h200, 32'h300, 1'b1);

`ifdef MATRIX_DMA_TIMEOUT_EN
        // Accelerator never finishes: exactly POLL_TIMEOUT status reads.
        polls_needed = 32'h4000_0000;
        fill_dst(32'h300);
        build_expected(32'h100, 32'h200, 32'h300, 8, 1'b0);
        d0 = n_done; s0 = n_status; w0 = n_sys_writes;
        start_run(32'h100, 32'h200, 32'h300);
        wait_done(3000);
        tick(); tick();
        check("to_err", 32'(err), 32'd1);
        check("to_status_reads", 32'(n_status - s0), 32'd8);
        check("to_no_writes", 32'(n_sys_writes - w0), 32'd0);
        check("to_done_once", 32'(n_done - d0), 32'd1);
        check("to_sb_drained", 32'(sb_q.size()), 32'd0);
`else
        s0 = 0; w0 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
